vector_alu: RTL and testbench
=============================

# vector_alu

Parametrised, time-multiplexed element-wise vector unit. It is the successor to the fully parallel bias adder in the activation datapath. It combines two `NUM_UNITS`-element vectors (`In_x`, `In_bias`) lane by lane using a runtime-selected operation: add, subtract, add+ReLU or max. Cost is set by `NUM_LANES`: that many physical integer datapaths are reused over `NUM_UNITS/NUM_LANES` beats. The unit sits between the systolic-array accumulator readout and the activation/writeback stage.

## Interface
Parameters:
- `DATA_WIDTH`, 16: element width, signed two's complement.
- `NUM_UNITS`, 64: vector length.
- `NUM_LANES`, 16: physical datapaths. Must divide `NUM_UNITS`. Beats `B = NUM_UNITS/NUM_LANES`.
- `SATURATE`, 1: 1 = saturate results to the signed range; 0 = wrap modulo 2^`DATA_WIDTH`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Sampled only in IDLE.
- `mode`  in  2  operation: 00 ADD x+b, 01 SUB x−b, 10 RELU max(0,x+b), 11 MAX max(x,b). Captured at start.
- `active_units`  in  `NUM_UNITS`  lane enable mask. Captured at start.
- `In_x`  in  `DATA_WIDTH` × [0:`NUM_UNITS`-1]  operand vector. Captured at start.
- `In_bias`  in  `DATA_WIDTH` × [0:`NUM_UNITS`-1]  second operand vector. Captured at start.
- `Out`  out  `DATA_WIDTH` × [0:`NUM_UNITS`-1]  result vector, registered.
- `ready`  out  1  result valid. Level signal.
- `busy`  out  1  operation in progress.

## Operation
- Reset values: state IDLE, `Out` all 0, `ready` 0, `busy` 0, beat counter 0, internal buffers 0.
- States:
  - IDLE: on `start` capture `mode`, `active_units`, `In_x`, `In_bias` into snapshot registers; clear `ready`; set `busy`; counter←0; go to COMPUTE. Otherwise hold.
  - COMPUTE: process elements `k*NUM_LANES … k*NUM_LANES+NUM_LANES-1` for counter value k, writing the result buffer. Counter increments. After k = B−1 go to DONE.
  - DONE: `Out` ← result buffer (all elements in one edge); `ready`←1; `busy`←0; go to IDLE.
- Inputs may change freely after the capture edge. Computation uses only the snapshot.
- Arithmetic:
  - Sign-extend operands to `DATA_WIDTH+1` bits and compute the sum or difference.
  - With `SATURATE`=1, clamp to [−2^(W−1), 2^(W−1)−1]. With `SATURATE`=0, truncate to W bits.
  - RELU applies max(0, ·) after saturation/wrap.
  - MAX is a signed compare with no overflow.
- Inactive lanes (captured mask bit 0) produce exactly 0 regardless of operands or mode.
- `start` while `busy` is ignored: no restart, no re-capture.
- `start` in the cycle DONE is active is also ignored (state not IDLE). It is accepted the following cycle.
- `ready` stays 1 until the next accepted `start` or reset. `Out` holds its value until the next DONE.
- Reset mid-operation: immediate return to reset values. The partial result is discarded and `Out` is zeroed.

## Timing
- `start` sampled at edge E0 (capture). Beats at edges E1…EB. DONE at edge E(B+1).
- `Out`/`ready` are valid after E(B+1): latency B+1 cycles. Default is 5 cycles.
- `busy` is high from after E0 through E(B+1). `ready` and `busy` are never both 1.
- Back-to-back throughput: one vector per B+2 cycles. Holding `start` high gives the next capture one cycle after `ready` rises.
- No combinational path from any input to any output.

## Test plan
- ADD, all lanes active, defaults: x[i]=100+i, b[i]=−30 → Out[i]=70+i. `ready` rises exactly 5 cycles after the start edge; `busy` high for 5 cycles.
- Saturation: ADD with x=32767, b=1 → 32767. SUB with x=−32768, b=1 → −32768. Same stimulus with `SATURATE`=0 → −32768 and 32767.
- RELU and MAX: RELU x=−5, b=2 → 0; RELU x=5, b=2 → 7. MAX x=−3, b=−7 → −3.
- Mask and capture: `active_units`=…0101 → odd lanes 0, even lanes computed. Changing the inputs and mask one cycle after start does not alter the result.
- Handshake: `start` pulsed during COMPUTE and during DONE is ignored (single `ready` rise, `Out` from first operands). Holding `start` high gives a second capture one cycle after `ready`, and `ready` drops at that capture.
- Reset during beat 2 → `Out` all 0, `ready`/`busy` 0 immediately. A subsequent start completes normally with the correct result.
- Parameter sweep: `NUM_LANES` = 64 (latency 2), 8 (latency 9) and 1 (latency 65), each with a random ADD checked against a reference model.

Source files
------------

// File: rtl/vector_alu.sv
`default_nettype none
// ============================================================================
// Module   : vector_alu
// Purpose  : Time-multiplexed element-wise vector unit. Combines two
//            NUM_UNITS-element signed vectors lane by lane with ADD, SUB,
//            ADD+ReLU or MAX. NUM_LANES physical datapaths are reused over
//            NUM_UNITS/NUM_LANES beats. Results are optionally saturated.
// Ports    : clk          - rising-edge clock
//            reset        - asynchronous active-high reset
//            start        - request, sampled only while idle
//            mode         - 00 ADD, 01 SUB, 10 RELU(x+b), 11 MAX(x,b)
//            active_units - per-element enable mask (disabled -> 0)
//            In_x/In_bias - operand vectors, captured at start
//            Out          - registered result vector
//            ready        - result valid (level, held until next start)
//            busy         - operation in progress
// Revision : 1.0 - initial release
// ============================================================================
module vector_alu #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_UNITS  = 64,
    parameter int NUM_LANES  = 16,
    parameter int SATURATE   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [NUM_UNITS-1:0]  active_units,
    input  logic [DATA_WIDTH-1:0] In_x    [0:NUM_UNITS-1],
    input  logic [DATA_WIDTH-1:0] In_bias [0:NUM_UNITS-1],
    output logic [DATA_WIDTH-1:0] Out     [0:NUM_UNITS-1],
    output logic                  ready,
    output logic                  busy
);

    localparam int C_BEATS = NUM_UNITS / NUM_LANES;
    localparam int C_CNT_W = (C_BEATS > 1) ? $clog2(C_BEATS) : 1;
    localparam logic [C_CNT_W-1:0] C_LAST_BEAT = C_CNT_W'(C_BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [C_CNT_W-1:0]      r_cnt;
    logic [1:0]              r_mode;
    logic [NUM_UNITS-1:0]    r_mask;
    logic [DATA_WIDTH-1:0]   r_x   [0:NUM_UNITS-1];
    logic [DATA_WIDTH-1:0]   r_b   [0:NUM_UNITS-1];
    logic [DATA_WIDTH-1:0]   r_res [0:NUM_UNITS-1];
    logic [DATA_WIDTH-1:0]   w_lane [0:NUM_LANES-1];

    // One element operation. Operands are widened by one bit so the true
    // sum/difference is always representable; overflow shows up as a
    // disagreement between the two top bits.
    function automatic logic [DATA_WIDTH-1:0] lane_op(
        input logic [1:0]            op,
        input logic [DATA_WIDTH-1:0] x,
        input logic [DATA_WIDTH-1:0] b
    );
        logic [DATA_WIDTH:0]   xe;
        logic [DATA_WIDTH:0]   be;
        logic [DATA_WIDTH:0]   s;
        logic [DATA_WIDTH-1:0] r;
        xe = {x[DATA_WIDTH-1], x};
        be = {b[DATA_WIDTH-1], b};
        s  = (op == 2'b01) ? (xe - be) : (xe + be);
        if ((SATURATE != 0) && (s[DATA_WIDTH] != s[DATA_WIDTH-1]))
            r = s[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                              : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else
            r = s[DATA_WIDTH-1:0];
        if ((op == 2'b10) && r[DATA_WIDTH-1])
            r = '0;
        if (op == 2'b11)
            r = ($signed(x) > $signed(b)) ? x : b;
        return r;
    endfunction

    // The snapshot is shifted down by NUM_LANES each beat, so the physical
    // lanes always read elements [0 .. NUM_LANES-1] and no wide per-beat
    // multiplexer is needed.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign w_lane[l] = r_mask[l] ? lane_op(r_mode, r_x[l], r_b[l]) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_COMPUTE;
            S_COMPUTE: if (r_cnt == C_LAST_BEAT) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_mode <= '0;
            r_mask <= '0;
            ready  <= 1'b0;
            busy   <= 1'b0;
            for (int j = 0; j < NUM_UNITS; j++) begin
                r_x[j]   <= '0;
                r_b[j]   <= '0;
                r_res[j] <= '0;
                Out[j]   <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_mask <= active_units;
                        r_cnt  <= '0;
                        ready  <= 1'b0;
                        busy   <= 1'b1;
                        for (int j = 0; j < NUM_UNITS; j++) begin
                            r_x[j] <= In_x[j];
                            r_b[j] <= In_bias[j];
                        end
                    end
                end
                S_COMPUTE: begin
                    // Results enter at the top of the buffer and sink by one
                    // beat per cycle; after the last beat beat k sits at
                    // elements k*NUM_LANES .. k*NUM_LANES+NUM_LANES-1.
                    for (int j = 0; j < NUM_UNITS - NUM_LANES; j++) begin
                        r_x[j]   <= r_x[j + NUM_LANES];
                        r_b[j]   <= r_b[j + NUM_LANES];
                        r_res[j] <= r_res[j + NUM_LANES];
                    end
                    for (int l = 0; l < NUM_LANES; l++)
                        r_res[NUM_UNITS - NUM_LANES + l] <= w_lane[l];
                    r_mask <= r_mask >> NUM_LANES;
                    r_cnt  <= r_cnt + C_CNT_W'(1);
                end
                S_DONE: begin
                    for (int j = 0; j < NUM_UNITS; j++)
                        Out[j] <= r_res[j];
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vector_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_alu
// Purpose  : Self-checking bench for vector_alu. Five instances share the
//            operand bus: defaults, wrap-around (SATURATE=0) and three lane
//            counts (64, 8, 1). Expected vectors come from an integer
//            reference model and are queued when an operation is started.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_alu;

    localparam int W = 16;
    localparam int N = 64;
    typedef logic [N*W-1:0] flat_t;

    logic          clk;
    logic          reset;
    logic [4:0]    st;
    logic [1:0]    mode;
    logic [N-1:0]  mask;
    logic [W-1:0]  in_x [0:N-1];
    logic [W-1:0]  in_b [0:N-1];
    logic [W-1:0]  out0 [0:N-1];
    logic [W-1:0]  out1 [0:N-1];
    logic [W-1:0]  out2 [0:N-1];
    logic [W-1:0]  out3 [0:N-1];
    logic [W-1:0]  out4 [0:N-1];
    logic [4:0]    rdy;
    logic [4:0]    bsy;
    flat_t         of [0:4];

    flat_t         exp_q [$];
    flat_t         last_exp;
    int            n_cmp;
    int            n_err;

    vector_alu #(.DATA_WIDTH(W), .NUM_UNITS(N), .NUM_LANES(16), .SATURATE(1)) u_dut (
        .clk(clk), .reset(reset), .start(st[0]), .mode(mode), .active_units(mask),
        .In_x(in_x), .In_bias(in_b), .Out(out0), .ready(rdy[0]), .busy(bsy[0]));
    vector_alu #(.DATA_WIDTH(W), .NUM_UNITS(N), .NUM_LANES(16), .SATURATE(0)) u_wrap (
        .clk(clk), .reset(reset), .start(st[1]), .mode(mode), .active_units(mask),
        .In_x(in_x), .In_bias(in_b), .Out(out1), .ready(rdy[1]), .busy(bsy[1]));
    vector_alu #(.DATA_WIDTH(W), .NUM_UNITS(N), .NUM_LANES(64), .SATURATE(1)) u_l64 (
        .clk(clk), .reset(reset), .start(st[2]), .mode(mode), .active_units(mask),
        .In_x(in_x), .In_bias(in_b), .Out(out2), .ready(rdy[2]), .busy(bsy[2]));
    vector_alu #(.DATA_WIDTH(W), .NUM_UNITS(N), .NUM_LANES(8), .SATURATE(1)) u_l8 (
        .clk(clk), .reset(reset), .start(st[3]), .mode(mode), .active_units(mask),
        .In_x(in_x), .In_bias(in_b), .Out(out3), .ready(rdy[3]), .busy(bsy[3]));
    vector_alu #(.DATA_WIDTH(W), .NUM_UNITS(N), .NUM_LANES(1), .SATURATE(1)) u_l1 (
        .clk(clk), .reset(reset), .start(st[4]), .mode(mode), .active_units(mask),
        .In_x(in_x), .In_bias(in_b), .Out(out4), .ready(rdy[4]), .busy(bsy[4]));

    always_comb begin
        for (int k = 0; k < 5; k++) of[k] = '0;
        for (int i = 0; i < N; i++) begin
            of[0][i*W +: W] = out0[i];
            of[1][i*W +: W] = out1[i];
            of[2][i*W +: W] = out2[i];
            of[3][i*W +: W] = out3[i];
            of[4][i*W +: W] = out4[i];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference element operation in plain integer arithmetic.
    function automatic logic [W-1:0] ref_op(input logic [1:0] m, input logic [W-1:0] x,
                                            input logic [W-1:0] b, input bit sat);
        int xi;
        int bi;
        int r;
        xi = int'($signed(x));
        bi = int'($signed(b));
        case (m)
            2'b01:   r = xi - bi;
            2'b11:   r = (xi > bi) ? xi : bi;
            default: r = xi + bi;
        endcase
        if (m != 2'b11) begin
            if (sat) begin
                if (r > 32767)  r = 32767;
                if (r < -32768) r = -32768;
            end else begin
                r = int'($signed(r[15:0]));
            end
        end
        if ((m == 2'b10) && (r < 0)) r = 0;
        return r[15:0];
    endfunction

    function automatic flat_t model(input bit sat);
        flat_t e;
        e = '0;
        for (int i = 0; i < N; i++)
            e[i*W +: W] = mask[i] ? ref_op(mode, in_x[i], in_b[i], sat) : '0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input flat_t obs, input flat_t exp);
        int idx;
        idx = 0;
        for (int i = N - 1; i >= 0; i--)
            if (obs[i*W +: W] !== exp[i*W +: W]) idx = i;
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: element %0d observed %0h expected %0h",
                   tag, idx, obs[idx*W +: W], exp[idx*W +: W]);
        end
    endtask

    task automatic push_exp(input int k);
        exp_q.push_back(model(k != 1));
    endtask

    task automatic rnd_ops();
        for (int i = 0; i < N; i++) begin
            in_x[i] = W'($urandom);
            in_b[i] = W'($urandom);
        end
    endtask

    task automatic scramble();
        rnd_ops();
        mask = {$urandom, $urandom};
        mode = 2'($urandom);
    endtask

    task automatic fill(input logic [W-1:0] xv, input logic [W-1:0] bv);
        for (int i = 0; i < N; i++) begin
            in_x[i] = xv;
            in_b[i] = bv;
        end
    endtask

    // Entered one step after the capture edge; lat = 0 skips timing checks.
    task automatic wait_ready(input int k, input int lat);
        int n;
        int bc;
        n  = 0;
        bc = bsy[k] ? 1 : 0;
        while (!rdy[k] && n < 300) begin
            @(posedge clk); #1;
            n++;
            if (bsy[k]) bc++;
        end
        chk("ready_rise", 32'(rdy[k]), 32'd1);
        if (lat > 0) begin
            chk("latency", n, lat);
            chk("busy_cycles", bc, lat);
        end
        chk("busy_at_ready", 32'(bsy[k]), 32'd0);
        chk("sb_depth", exp_q.size(), 32'd1);
        if (exp_q.size() > 0) begin
            last_exp = exp_q.pop_front();
            chkv("result", of[k], last_exp);
        end
    endtask

    task automatic run(input int k, input int lat, input bit scr);
        st[k] = 1'b1;
        @(posedge clk); #1;
        st[k] = 1'b0;
        push_exp(k);
        if (scr) scramble();
        wait_ready(k, lat);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        st    = '0;
        mode  = 2'b00;
        mask  = '1;
        fill('0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(rdy[0]), 32'd0);
        chk("rst_busy", 32'(bsy[0]), 32'd0);
        chkv("rst_out", of[0], '0);
        reset = 1'b0;
        @(posedge clk); #1;

        // ADD, all lanes: x = 100+i, b = -30
        for (int i = 0; i < N; i++) begin
            in_x[i] = W'(100 + i);
            in_b[i] = 16'hFFE2;
        end
        run(0, 5, 1'b0);
        chk("add_el5", 32'(of[0][5*W +: W]), 32'd75);

        // Saturating vs wrapping overflow
        mode = 2'b00; fill(16'h7FFF, 16'h0001);
        run(0, 5, 1'b0);
        chk("add_sat", 32'(of[0][0 +: W]), 32'h7FFF);
        run(1, 5, 1'b0);
        chk("add_wrap", 32'(of[1][0 +: W]), 32'h8000);
        mode = 2'b01; fill(16'h8000, 16'h0001);
        run(0, 5, 1'b0);
        chk("sub_sat", 32'(of[0][0 +: W]), 32'h8000);
        run(1, 5, 1'b0);
        chk("sub_wrap", 32'(of[1][0 +: W]), 32'h7FFF);

        // RELU: even x=-5, odd x=5, b=2
        mode = 2'b10;
        for (int i = 0; i < N; i++) begin
            in_x[i] = (i % 2 == 0) ? 16'hFFFB : 16'h0005;
            in_b[i] = 16'h0002;
        end
        run(0, 5, 1'b0);
        chk("relu_neg", 32'(of[0][0 +: W]), 32'h0000);
        chk("relu_pos", 32'(of[0][1*W +: W]), 32'h0007);

        // MAX: x=-3, b=-7
        mode = 2'b11; fill(16'hFFFD, 16'hFFF9);
        run(0, 5, 1'b0);
        chk("max", 32'(of[0][3*W +: W]), 32'hFFFD);

        // Mask ...0101 with inputs scrambled right after capture
        mode = 2'b00; mask = {16{4'b0101}}; rnd_ops();
        run(0, 5, 1'b1);
        chk("mask_odd", 32'(of[0][1*W +: W]), 32'h0000);

        // start during COMPUTE and during DONE is ignored
        mode = 2'b00; mask = '1; rnd_ops();
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        push_exp(0);
        scramble();
        @(posedge clk); #1;
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        st[0] = 1'b1;
        wait_ready(0, 0);
        st[0] = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("ign_ready_held", 32'(rdy[0]), 32'd1);
        chk("ign_busy", 32'(bsy[0]), 32'd0);
        chkv("ign_out_held", of[0], last_exp);

        // Holding start: second capture one cycle after ready
        mode = 2'b01; mask = '1; rnd_ops();
        st[0] = 1'b1;
        @(posedge clk); #1;
        push_exp(0);
        rnd_ops();
        mode = 2'b10;
        wait_ready(0, 5);
        push_exp(0);
        @(posedge clk); #1;
        chk("hold_ready_drop", 32'(rdy[0]), 32'd0);
        chk("hold_busy", 32'(bsy[0]), 32'd1);
        st[0] = 1'b0;
        wait_ready(0, 5);

        // Reset during the second beat
        mode = 2'b00; mask = '1; rnd_ops();
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1;
        #1;
        chkv("midrst_out", of[0], '0);
        chk("midrst_ready", 32'(rdy[0]), 32'd0);
        chk("midrst_busy", 32'(bsy[0]), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        rnd_ops();
        run(0, 5, 1'b0);

        // Lane-count sweep with random ADD
        mode = 2'b00; mask = '1;
        rnd_ops(); run(2, 2, 1'b0);
        rnd_ops(); run(3, 9, 1'b0);
        rnd_ops(); run(4, 65, 1'b0);
        rnd_ops(); mask = {$urandom, $urandom}; mode = 2'($urandom);
        run(4, 65, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
